// File: rtl/iir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : iir_out_fifo
// Brief    : Show-ahead circular FIFO buffering IIR output samples toward a
//            VOUT/RDY sink, with a sticky overflow flag for dropped samples.
// Revision : 1.0 - initial release
// ============================================================================
module iir_out_fifo #(
    parameter int DW    = 14,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          VIN,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] DOUT,
    output logic          VOUT,
    input  logic          RDY,
    input  logic          CLR_OVF,
    output logic          FULL,
    output logic          EMPTY,
    output logic [AW:0]   LEVEL,
    output logic          OVF
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, push;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        // Full when the pointers address the same slot but differ in lap.
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = ~empty & RDY;
        push     = VIN & (~full | pop);
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        ovf_d    = ovf_q;
        if (VIN & full & ~RDY) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately not reset; DOUT is masked while empty instead.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= DIN;
        end
    end

    assign DOUT  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign VOUT  = ~empty;
    assign EMPTY = empty;
    assign FULL  = full;
    assign LEVEL = wr_ptr_q - rd_ptr_q;
    assign OVF   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_out_fifo
// Brief    : Scoreboard bench for iir_out_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_out_fifo;

    localparam int DW    = 14;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic          VIN = 1'b0;
    logic [DW-1:0] DIN = '0;
    logic [DW-1:0] DOUT;
    logic          VOUT;
    logic          RDY = 1'b0;
    logic          CLR_OVF = 1'b0;
    logic          FULL;
    logic          EMPTY;
    logic [AW:0]   LEVEL;
    logic          OVF;

    logic [DW-1:0] sb[$];
    logic          model_ovf = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    iir_out_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RST_n(RST_n), .VIN(VIN), .DIN(DIN), .DOUT(DOUT),
        .VOUT(VOUT), .RDY(RDY), .CLR_OVF(CLR_OVF), .FULL(FULL),
        .EMPTY(EMPTY), .LEVEL(LEVEL), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    // Drives one cycle at the falling edge, pops/compares the scoreboard on
    // handshake, pushes accepted samples, then returns 1 time unit after the
    // rising edge.
    task automatic drive_cycle(input logic vin, input logic [DW-1:0] din,
                               input logic rdy, input logic clr);
        logic pop, full;
        @(negedge CLK);
        VIN = vin; DIN = din; RDY = rdy; CLR_OVF = clr;
        #1;
        full = (sb.size() == DEPTH);
        pop  = rdy && (sb.size() != 0);
        if (pop) begin
            n_checks++;
            if (VOUT !== 1'b1 || DOUT !== sb[0]) begin
                n_fail++;
                $display("FAIL sb_pop: DOUT=%h VOUT=%b expected DOUT=%h VOUT=1",
                         DOUT, VOUT, sb[0]);
            end
            void'(sb.pop_front());
        end
        if (vin && (!full || pop)) sb.push_back(din);
        if (vin && full && !rdy) model_ovf = 1'b1;
        else if (clr) model_ovf = 1'b0;
        @(posedge CLK);
        #1;
        VIN = 1'b0; RDY = 1'b0; CLR_OVF = 1'b0;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        #3;
        n_checks++;
        if (VOUT !== 1'b0 || EMPTY !== 1'b1 || FULL !== 1'b0 ||
            LEVEL !== '0 || DOUT !== '0 || OVF !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: VOUT=%b EMPTY=%b FULL=%b LEVEL=%0d DOUT=%h OVF=%b expected 0 1 0 0 0 0",
                     VOUT, EMPTY, FULL, LEVEL, DOUT, OVF);
        end
        @(negedge CLK);
        RST_n = 1'b1;
    endtask

    task automatic test_pass_through();
        logic [DW-1:0] vals[3];
        vals[0] = 14'h0001; vals[1] = 14'h3FFF; vals[2] = 14'h2000;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, vals[i], 1'b1, 1'b0);
            n_checks++;
            if (DOUT !== vals[i] || VOUT !== 1'b1 || LEVEL > 1 || OVF !== 1'b0) begin
                n_fail++;
                $display("FAIL pass_through[%0d]: DOUT=%h VOUT=%b LEVEL=%0d OVF=%b expected DOUT=%h VOUT=1 LEVEL<=1 OVF=0",
                         i, DOUT, VOUT, LEVEL, OVF, vals[i]);
            end
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (EMPTY !== 1'b1 || DOUT !== '0) begin
            n_fail++;
            $display("FAIL pass_through_empty: EMPTY=%b DOUT=%h expected 1 0", EMPTY, DOUT);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1, DW'(i), 1'b0, 1'b0);
            n_checks++;
            if (LEVEL !== (AW+1)'(i) || FULL !== (i == 8)) begin
                n_fail++;
                $display("FAIL fill_level[%0d]: LEVEL=%0d FULL=%b expected %0d %b",
                         i, LEVEL, FULL, i, (i == 8));
            end
        end
        drive_cycle(1'b1, 14'd9, 1'b0, 1'b0);
        n_checks++;
        if (OVF !== 1'b1 || LEVEL !== 4'd8 || DOUT !== 14'd1) begin
            n_fail++;
            $display("FAIL overflow_drop: OVF=%b LEVEL=%0d DOUT=%h expected 1 8 0001",
                     OVF, LEVEL, DOUT);
        end
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (EMPTY !== 1'b1 || sb.size() != 0 || OVF !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty: EMPTY=%b sb=%0d OVF=%b expected 1 0 1",
                     EMPTY, sb.size(), OVF);
        end
    endtask

    task automatic test_full_push_pop();
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (OVF !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: OVF=%b expected 0", OVF);
        end
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, DW'(14'h100 + i), 1'b0, 1'b0);
        drive_cycle(1'b1, 14'h1234, 1'b1, 1'b0);
        n_checks++;
        if (LEVEL !== 4'd8 || FULL !== 1'b1 || OVF !== 1'b0 || DOUT !== 14'h101) begin
            n_fail++;
            $display("FAIL full_push_pop: LEVEL=%0d FULL=%b OVF=%b DOUT=%h expected 8 1 0 0101",
                     LEVEL, FULL, OVF, DOUT);
        end
        for (int i = 0; i < 7; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (DOUT !== 14'h1234 || LEVEL !== 4'd1) begin
            n_fail++;
            $display("FAIL full_last_out: DOUT=%h LEVEL=%0d expected 1234 1", DOUT, LEVEL);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap_around();
        int pushed = 0;
        int cyc = 0;
        while (pushed < 20) begin
            if (cyc % 2 == 0) begin
                drive_cycle(1'b1, DW'(14'h2A0 + pushed * 7), cyc[1], 1'b0);
                pushed++;
            end else begin
                drive_cycle(1'b0, '0, cyc[1], 1'b0);
            end
            cyc++;
        end
        n_checks++;
        if (LEVEL !== (AW+1)'(sb.size()) || OVF !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_level: LEVEL=%0d OVF=%b expected %0d 0", LEVEL, OVF, sb.size());
        end
        for (int i = 0; i < 10 && sb.size() != 0; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (EMPTY !== 1'b1 || sb.size() != 0 || OVF !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_drain: EMPTY=%b sb=%0d OVF=%b expected 1 0 0",
                     EMPTY, sb.size(), OVF);
        end
    endtask

    task automatic test_ovf_control();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, DW'(14'h0A0 + i), 1'b0, 1'b0);
        drive_cycle(1'b1, 14'h3333, 1'b0, 1'b1);
        n_checks++;
        if (OVF !== 1'b1 || OVF !== model_ovf) begin
            n_fail++;
            $display("FAIL ovf_set_beats_clr: OVF=%b expected 1", OVF);
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (OVF !== 1'b0 || LEVEL !== 4'd8) begin
            n_fail++;
            $display("FAIL ovf_clr: OVF=%b LEVEL=%0d expected 0 8", OVF, LEVEL);
        end
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, DW'(14'h0C0 + i), 1'b0, 1'b0);
        n_checks++;
        if (LEVEL !== 4'd5) begin
            n_fail++;
            $display("FAIL mid_level: LEVEL=%0d expected 5", LEVEL);
        end
        #1;
        RST_n = 1'b0;
        #1;
        n_checks++;
        if (VOUT !== 1'b0 || LEVEL !== '0 || DOUT !== '0 || EMPTY !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: VOUT=%b LEVEL=%0d DOUT=%h EMPTY=%b expected 0 0 0 1",
                     VOUT, LEVEL, DOUT, EMPTY);
        end
        sb.delete();
        model_ovf = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        drive_cycle(1'b1, 14'h1ABC, 1'b0, 1'b0);
        n_checks++;
        if (DOUT !== 14'h1ABC || LEVEL !== 4'd1) begin
            n_fail++;
            $display("FAIL post_reset_first: DOUT=%h LEVEL=%0d expected 1abc 1", DOUT, LEVEL);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap_around();
        test_ovf_control();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
